// File: rtl/alu_types.sv
// Shared ALU operation encoding for the rv32i execution datapath.
package alu_types;

    typedef enum logic [3:0] {
        INVALID = 4'b0000,
        AND     = 4'b0001,
        OR      = 4'b0010,
        XOR     = 4'b0011,
        SLL     = 4'b0101,
        SRL     = 4'b0110,
        SRA     = 4'b0111,
        ADD     = 4'b1000,
        SUB     = 4'b1100,
        SLT     = 4'b1101,
        SLTU    = 4'b1111
    } alu_control_t;

    function automatic string alu_control_name(input alu_control_t op);
        case (op)
            INVALID: return "INVALID";
            AND:     return "AND";
            OR:      return "OR";
            XOR:     return "XOR";
            SLL:     return "SLL";
            SRL:     return "SRL";
            SRA:     return "SRA";
            ADD:     return "ADD";
            SUB:     return "SUB";
            SLT:     return "SLT";
            SLTU:    return "SLTU";
            default: return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/alu_behavioural.sv
// Combinational rv32i ALU with signed-overflow, zero and equality flags.
module alu_behavioural
    import alu_types::*;
(
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  alu_control_t alu_control,
    output logic [31:0]  result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] sum;
    logic signed [31:0] diff;

    assign a_s  = signed'(a);
    assign b_s  = signed'(b);
    assign sum  = a_s + b_s;
    assign diff = a_s - b_s;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_control)
            ADD: begin
                result   = sum;
                overflow = (a_s[31] == b_s[31]) && (sum[31] != a_s[31]);
            end
            SUB: begin
                result   = diff;
                overflow = (a_s[31] != b_s[31]) && (diff[31] != a_s[31]);
            end
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            SLL:     result = a << b[4:0];
            SRL:     result = a >> b[4:0];
            SRA:     result = a_s >>> b[4:0];
            SLT:     result = {31'd0, a_s < b_s};
            SLTU:    result = {31'd0, a < b};
            default: result = '0;
        endcase
    end

    assign zero  = (result == 32'd0);
    assign equal = (a == b);

endmodule

// File: rtl/register.sv
// Generic N-bit load-enable register with asynchronous active-low reset.
module register #(
    parameter int              N     = 32,
    parameter logic [N-1:0]    RESET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit integer register file: two combinational read ports, one write port, x0 hardwired to 0.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] reg_data1,
    output logic [31:0] reg_data2,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    input  logic [31:0] rfile_wr_data
);

    logic [31:0] regs [0:31];

    // Entry 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (ena && reg_write && (rd != 5'd0)) begin
            regs[rd] <= rfile_wr_data;
        end
    end

    assign reg_data1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign reg_data2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

endmodule

// File: rtl/rv32i_exec_unit.sv
// Execution datapath slice: register file, behavioural ALU and the registered ALU result.
module rv32i_exec_unit
    import alu_types::*;
#(
    parameter logic [31:0] RESULT_RESET = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    output logic [31:0]  reg_data1,
    output logic [31:0]  reg_data2,
    input  logic         reg_write,
    input  logic [4:0]   rd,
    input  logic [31:0]  rfile_wr_data,
    input  logic [31:0]  src_a,
    input  logic [31:0]  src_b,
    input  alu_control_t alu_control,
    output logic [31:0]  alu_result,
    output logic         overflow,
    output logic         zero,
    output logic         equal,
    input  logic         result_ena,
    output logic [31:0]  alu_result_q
);

    register_file u_register_file (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .rs1           (rs1),
        .rs2           (rs2),
        .reg_data1     (reg_data1),
        .reg_data2     (reg_data2),
        .reg_write     (reg_write),
        .rd            (rd),
        .rfile_wr_data (rfile_wr_data)
    );

    alu_behavioural u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (alu_control),
        .result      (alu_result),
        .overflow    (overflow),
        .zero        (zero),
        .equal       (equal)
    );

    register #(
        .N     (32),
        .RESET (RESULT_RESET)
    ) u_result_reg (
        .clk (clk),
        .rst (rst),
        .ena (ena && result_ena),
        .d   (alu_result),
        .q   (alu_result_q)
    );

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Directed scoreboard bench for rv32i_exec_unit: expectations queued on drive, popped on sample.
module tb_rv32i_exec_unit;
    import alu_types::*;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [31:0]  reg_data1;
    logic [31:0]  reg_data2;
    logic         reg_write;
    logic [4:0]   rd;
    logic [31:0]  rfile_wr_data;
    logic [31:0]  src_a;
    logic [31:0]  src_b;
    alu_control_t alu_control;
    logic [31:0]  alu_result;
    logic         overflow;
    logic         zero;
    logic         equal;
    logic         result_ena;
    logic [31:0]  alu_result_q;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb [$];

    rv32i_exec_unit #(.RESULT_RESET(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .rs1           (rs1),
        .rs2           (rs2),
        .reg_data1     (reg_data1),
        .reg_data2     (reg_data2),
        .reg_write     (reg_write),
        .rd            (rd),
        .rfile_wr_data (rfile_wr_data),
        .src_a         (src_a),
        .src_b         (src_b),
        .alu_control   (alu_control),
        .alu_result    (alu_result),
        .overflow      (overflow),
        .zero          (zero),
        .equal         (equal),
        .result_ena    (result_ena),
        .alu_result_q  (alu_result_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] exp);
        sb.push_back(exp);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, overflow, zero, equal};
    endfunction

    // Drive one ALU operation, queue its result and {overflow,zero,equal}, then sample both.
    task automatic alu_case(input logic [31:0] a, input logic [31:0] b, input alu_control_t op,
                            input logic [31:0] exp_res, input logic [2:0] exp_flags);
        src_a       = a;
        src_b       = b;
        alu_control = op;
        push(exp_res);
        push({29'd0, exp_flags});
        #1;
        check($sformatf("%s_result", alu_control_name(op)), alu_result);
        check($sformatf("%s_flags", alu_control_name(op)), flags());
    endtask

    initial begin
        rst           = 1'b0;
        ena           = 1'b1;
        rs1           = 5'd5;
        rs2           = 5'd6;
        reg_write     = 1'b0;
        rd            = 5'd0;
        rfile_wr_data = 32'd0;
        src_a         = 32'd3;
        src_b         = 32'd4;
        alu_control   = ADD;
        result_ena    = 1'b0;
        #1;
        push(32'd0); check("reset_rd1", reg_data1);
        push(32'd0); check("reset_q", alu_result_q);
        push(32'd7); check("alu_during_reset", alu_result);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();

        // x0 discards writes
        reg_write = 1'b1; rd = 5'd0; rfile_wr_data = 32'hDEADBEEF; rs1 = 5'd0;
        step();
        push(32'd0); check("x0_write", reg_data1);

        // write x5, x6; old value visible until the edge
        rd = 5'd5; rfile_wr_data = 32'd7; rs1 = 5'd5;
        #1;
        push(32'd0); check("rdw_old_value", reg_data1);
        step();
        rd = 5'd6; rfile_wr_data = 32'hFFFF_FFF9;
        step();
        reg_write = 1'b0;
        push(32'd7);          check("x5_read", reg_data1);
        push(32'hFFFF_FFF9);  check("x6_read", reg_data2);

        // ena=0 blocks register file and result register
        ena = 1'b0; reg_write = 1'b1; rd = 5'd5; rfile_wr_data = 32'h1234;
        result_ena = 1'b1; alu_control = ADD; src_a = 32'd100; src_b = 32'd1;
        step();
        push(32'd7); check("ena0_rf_hold", reg_data1);
        push(32'd0); check("ena0_q_hold", alu_result_q);
        ena = 1'b1; reg_write = 1'b0; result_ena = 1'b0;

        alu_case(32'd7,          32'hFFFF_FFF9, ADD,  32'd0,          3'b010);
        alu_case(32'h7FFF_FFFF,  32'd1,         ADD,  32'h8000_0000,  3'b100);
        alu_case(32'h8000_0000,  32'd1,         SUB,  32'h7FFF_FFFF,  3'b100);
        alu_case(32'd9,          32'd4,         SUB,  32'd5,          3'b000);
        alu_case(32'hFFFF_FFFF,  32'd1,         SLT,  32'd1,          3'b000);
        alu_case(32'hFFFF_FFFF,  32'd1,         SLTU, 32'd0,          3'b010);
        alu_case(32'h8000_0000,  32'd4,         SRA,  32'hF800_0000,  3'b000);
        alu_case(32'h8000_0000,  32'd4,         SRL,  32'h0800_0000,  3'b000);
        alu_case(32'd1,          32'd33,        SLL,  32'd2,          3'b000);
        alu_case(32'hF0F0_F0F0,  32'h0FF0_0FF0, AND,  32'h00F0_00F0,  3'b000);
        alu_case(32'hF0F0_F0F0,  32'h0FF0_0FF0, OR,   32'hFFF0_FFF0,  3'b000);
        alu_case(32'd5,          32'd5,         XOR,  32'd0,          3'b011);
        alu_case(32'h7FFF_FFFF,  32'd1,         INVALID, 32'd0,       3'b010);

        // result register load with simultaneous register write
        src_a = 32'd3; src_b = 32'd4; alu_control = ADD; result_ena = 1'b1;
        reg_write = 1'b1; rd = 5'd7; rfile_wr_data = 32'd99; rs2 = 5'd7;
        push(32'd0); check("q_before_edge", alu_result_q);
        step();
        push(32'd7);  check("q_load", alu_result_q);
        push(32'd99); check("x7_simul_write", reg_data2);
        result_ena = 1'b0; reg_write = 1'b0; src_a = 32'd10; src_b = 32'd20;
        step();
        push(32'd7); check("q_hold", alu_result_q);

        // reset mid-cycle with a write pending
        reg_write = 1'b1; rd = 5'd5; rfile_wr_data = 32'd55; rs1 = 5'd5;
        #3;
        rst = 1'b0;
        #1;
        push(32'd0); check("async_rst_x5", reg_data1);
        push(32'd0); check("async_rst_x7", reg_data2);
        push(32'd0); check("async_rst_q", alu_result_q);
        step();
        push(32'd0); check("rst_write_lost", reg_data1);
        reg_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        push(32'd0); check("post_rst_x5", reg_data1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
